aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_pkg.sv | 27 ++
 rtl/aes_round_ctrl.sv | 134 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_ctrl_pkg
//   Shared definitions for the AES round controller: FSM state encoding,
//   round counts for the two supported key lengths, and the width of the
//   round / key-schedule index.
//   No ports (package).
// ---------------------------------------------------------------------------
package aes_ctrl_pkg;

    localparam int ROUND_W = 4;

    localparam logic [ROUND_W-1:0] NR_128 = 4'd10;
    localparam logic [ROUND_W-1:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } aes_state_t;

    // Number of rounds for the selected key length.
    function automatic logic [ROUND_W-1:0] nr_for(input logic key256);
        return key256 ? NR_256 : NR_128;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//   Sequencing controller for an iterative AES encryption datapath. Accepts
//   one block request, pulses ld_state for the initial key addition, then
//   steps the state register once every ROUND_LAT cycles for Nr rounds
//   (Nr = 10 for AES-128, 14 for AES-256) and finally presents the result
//   until the consumer takes it.
//
//   Parameter
//     ROUND_LAT   datapath cycles per round, legal range 1..15
//   Ports
//     clock       sole clock, rising edge
//     reset       synchronous, active-high
//     in_valid    request to encrypt one block
//     in_ready    request can be accepted (IDLE and not in reset)
//     key256      key length select, sampled on accept (0 = 128, 1 = 256)
//     ld_state    one-cycle pulse: load plaintext ^ round key 0
//     round_idx   current round / key-schedule index
//     step_en     state register captures the datapath output
//     mix_bypass  final round, MixColumns skipped
//     busy        encryption in progress (LOAD or RUN)
//     out_valid   ciphertext valid in the state register
//     out_ready   consumer accepts the ciphertext
//     fsm_state   current FSM state, for observation only
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. in_valid is ignored outside IDLE; out_valid stays 1 and the
//   result stays put until out_ready is seen with it.
// ---------------------------------------------------------------------------
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int ROUND_LAT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               key256,
    output logic               ld_state,
    output logic [ROUND_W-1:0] round_idx,
    output logic               step_en,
    output logic               mix_bypass,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output aes_state_t         fsm_state
);

    localparam int CYC_W = 4;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(ROUND_LAT - 1);

    aes_state_t         state;
    aes_state_t         state_n;
    logic [CYC_W-1:0]   cyc;
    logic [CYC_W-1:0]   cyc_n;
    logic [ROUND_W-1:0] round_n;
    logic [ROUND_W-1:0] nr;
    logic [ROUND_W-1:0] nr_n;
    logic               accept;
    logic               last_cyc;

    // in_ready is the only output allowed to see an input (reset) directly;
    // everything else decodes registered state.
    assign in_ready = (state == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign last_cyc = (cyc == LAST_CYC);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cyc       <= '0;
            round_idx <= '0;
            nr        <= NR_128;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            round_idx <= round_n;
            nr        <= nr_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        round_n = round_idx;
        nr_n    = nr;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_LOAD;
                    cyc_n   = '0;
                    round_n = '0;
                    nr_n    = nr_for(key256);
                end
            end
            ST_LOAD: begin
                state_n = ST_RUN;
                cyc_n   = '0;
                round_n = 4'd1;
            end
            ST_RUN: begin
                if (last_cyc) begin
                    cyc_n = '0;
                    // Final round keeps its index visible through DONE.
                    if (round_idx == nr) begin
                        state_n = ST_DONE;
                    end else begin
                        round_n = round_idx + 4'd1;
                    end
                end else begin
                    cyc_n = cyc + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                    round_n = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign ld_state   = (state == ST_LOAD);
    assign step_en    = (state == ST_RUN) && last_cyc;
    assign mix_bypass = (state == ST_RUN) && (round_idx == nr);
    assign busy       = (state == ST_LOAD) || (state == ST_RUN);
    assign out_valid  = (state == ST_DONE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//   Self-checking bench for aes_round_ctrl. Main instance uses the default
//   ROUND_LAT of 4; a second instance uses ROUND_LAT = 1.
//   The reference model derives every event time from the accept cycle:
//   LOAD at +1, k-th step at +1+k*RL, final round window, result at
//   +2+Nr*RL. Expected result records go into exp_q when a request is
//   accepted and are popped by the monitor when out_valid rises.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    localparam int RL = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       in_valid = 1'b0;
    logic       key256 = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, ld_state, step_en, mix_bypass, busy, out_valid;
    logic [3:0] round_idx;
    aes_state_t fsm_state;

    logic       f_in_valid = 1'b0;
    logic       f_key256 = 1'b0;
    logic       f_out_ready = 1'b1;
    logic       f_in_ready, f_ld_state, f_step_en, f_mix_bypass, f_busy, f_out_valid;
    logic [3:0] f_round_idx;
    aes_state_t f_fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    aes_round_ctrl #(.ROUND_LAT(RL)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .key256(key256),
        .ld_state(ld_state), .round_idx(round_idx), .step_en(step_en),
        .mix_bypass(mix_bypass), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .fsm_state(fsm_state)
    );

    aes_round_ctrl #(.ROUND_LAT(1)) u_fast (
        .clock(clock), .reset(reset),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .key256(f_key256),
        .ld_state(f_ld_state), .round_idx(f_round_idx), .step_en(f_step_en),
        .mix_bypass(f_mix_bypass), .busy(f_busy), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .fsm_state(f_fsm_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic int nr_of(input logic k);
        return k ? 14 : 10;
    endfunction

    // ---------------- scoreboard monitor (main instance) ----------------
    logic [35:0] exp_q[$];
    logic [35:0] exp_e;
    bit          mon_active;
    bit          prev_ov;
    bit          expect_idle;
    int          acc_cyc, blk_nr, steps_seen, mix_seen, mon_nr;

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            mon_active  = 0;
            prev_ov     = 0;
            expect_idle = 0;
        end else begin
            if (expect_idle) begin
                check_eq("ov_release_valid", out_valid, 0);
                check_eq("ov_release_ready", in_ready, 1);
            end
            expect_idle = out_valid && out_ready;

            if (ld_state)
                check_eq("ld_time", mon_active ? cyc_cnt - acc_cyc : -1, 1);

            if (step_en) begin
                steps_seen++;
                check_eq("step_time", mon_active ? cyc_cnt - acc_cyc : -1, 1 + steps_seen * RL);
                check_eq("step_vs_ld", ld_state, 0);
            end

            if (mix_bypass) begin
                mix_seen++;
                check_eq("mix_time", mon_active ? cyc_cnt - acc_cyc : -1,
                         1 + (blk_nr - 1) * RL + mix_seen);
            end

            if (out_valid && !prev_ov) begin
                check_eq("ov_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check_eq("ov_time", cyc_cnt, exp_e[31:0]);
                    check_eq("step_count", steps_seen, exp_e[35:32]);
                    check_eq("mix_count", mix_seen, RL);
                end
                mon_active = 0;
            end
            prev_ov = out_valid;

            if (in_valid && in_ready) begin
                check_eq("accept_not_busy", busy, 0);
                mon_nr = nr_of(key256);
                exp_q.push_back({4'(mon_nr), 32'(cyc_cnt + 2 + mon_nr * RL)});
                mon_active = 1;
                acc_cyc    = cyc_cnt;
                blk_nr     = mon_nr;
                steps_seen = 0;
                mix_seen   = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(output int acc);
        bit got = 0;
        acc = -1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1;
                acc = cyc_cnt;
            end
        end
        check_eq("accept_wait", got, 1);
    endtask

    // One block: hold = cycles out_ready stays low after out_valid rises.
    task automatic run_block(input logic key, input bit toggle, input int hold, input int exp_lat);
        int acc, len;
        bit got;
        out_ready = (hold == 0);
        @(posedge clock); #1;
        in_valid = 1'b1;
        key256   = key;
        wait_accept(acc);
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (toggle) key256 = ~key;
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (out_valid) got = 1;
        end
        check_eq("ov_wait", got, 1);
        check_eq("latency", cyc_cnt - acc, exp_lat);
        len = 1;
        for (int n = 0; n < 50; n++) begin
            if (len == hold) begin
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
            @(negedge clock);
            if (!out_valid) break;
            len++;
            check_eq("in_ready_in_done", in_ready, 0);
        end
        check_eq("ov_length", len, hold + 1);
        check_eq("idle_after_done", in_ready, 1);
    endtask

    task automatic back_to_back(input logic key);
        int acc1 = -1, acc2 = -1, v1 = -1;
        bit got;
        out_ready = 1'b1;
        @(posedge clock); #1;
        key256   = key;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && acc2 < 0; n++) begin
            @(negedge clock);
            if (in_valid && in_ready) begin
                if (acc1 < 0) acc1 = cyc_cnt;
                else          acc2 = cyc_cnt;
            end
            if (out_valid && v1 < 0) v1 = cyc_cnt;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        check_eq("b2b_first_lat", v1 - acc1, 2 + nr_of(key) * RL);
        check_eq("b2b_second_gap", acc2 - v1, 1);
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (out_valid) got = 1;
        end
        check_eq("b2b_second_ov", got, 1);
        @(negedge clock);
    endtask

    task automatic reset_mid_run();
        int acc;
        bit got = 0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b1;
        key256   = 1'b0;
        wait_accept(acc);
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            if (round_idx == 4'd6) got = 1;
        end
        check_eq("reach_round6", got, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_in_ready_low", in_ready, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_step_en", step_en, 0);
        check_eq("rst_round_idx", round_idx, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        repeat (70) @(negedge clock);
    endtask

    task automatic fast_block();
        int acc = -1, first = -1, last = -1, ov = -1, steps = 0;
        @(posedge clock); #1;
        f_in_valid = 1'b1;
        f_key256   = 1'b0;
        for (int n = 0; n < 20 && acc < 0; n++) begin
            @(negedge clock);
            if (f_in_ready) acc = cyc_cnt;
        end
        @(posedge clock); #1;
        f_in_valid = 1'b0;
        for (int n = 0; n < 40 && ov < 0; n++) begin
            @(negedge clock);
            if (f_step_en) begin
                steps++;
                if (first < 0) first = cyc_cnt;
                last = cyc_cnt;
            end
            if (f_out_valid) ov = cyc_cnt;
        end
        check_eq("fast_steps", steps, 10);
        check_eq("fast_first_step", first - acc, 2);
        check_eq("fast_consecutive", last - first + 1, 10);
        check_eq("fast_ov_time", ov - acc, 12);
        @(negedge clock);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic k;
        bit   t;
        int   h;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_f_in_ready", f_in_ready, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("post_rst_in_ready", in_ready, 1);
        check_eq("post_rst_ld_state", ld_state, 0);
        check_eq("post_rst_step_en", step_en, 0);
        check_eq("post_rst_mix", mix_bypass, 0);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_out_valid", out_valid, 0);
        check_eq("post_rst_round_idx", round_idx, 0);

        run_block(1'b0, 1'b0, 0, 42);   // AES-128, consumer ready
        run_block(1'b1, 1'b1, 0, 58);   // AES-256, key256 flipped after accept
        run_block(1'b0, 1'b0, 5, 42);   // consumer stalls 5 cycles
        reset_mid_run();
        back_to_back(1'b0);
        back_to_back(1'b1);

        for (int i = 0; i < 8; i++) begin
            k = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            h = $urandom_range(0, 3);
            run_block(k, t, h, 2 + nr_of(k) * RL);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        fast_block();

        repeat (3) @(negedge clock);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
